hazard_controller: RTL
======================

Name: hazard_controller

Overview:
Sequencing controller for the 5-stage pipelined RV32I core. It tracks destination-register tags for the EX, MEM and WB stages, then produces:
- stall and flush enables for the pipeline registers
- operand-forwarding selects for the EX-stage ALU
- a saturating stall-cycle counter

It sits beside the ID-stage decoder and owns all pipeline-register enables.

Parameters:
CNT_W, 32, width of the stall-cycle performance counter (saturating)
XLEN_REGS, 32, architectural register count (x0 hardwired zero)

Ports:
clk  input  1  core clock
reset  input  1  synchronous active-high reset
id_instruction  input  32  raw instruction held in the IF/ID register
id_valid  input  1  IF/ID holds a real instruction
ex_branch_taken  input  1  branch/JAL/JALR in EX redirects PC this cycle
dmem_ready  input  1  data memory completes the MEM-stage access this cycle
stall_if  output  1  hold PC
stall_id  output  1  hold IF/ID register
flush_id  output  1  clear IF/ID to bubble
flush_ex  output  1  insert bubble into ID/EX
freeze  output  1  hold ID/EX, EX/MEM, MEM/WB
fwd_a  output  2  EX rs1 source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b  output  2  EX rs2 source, same encoding
stall_cycles  output  CNT_W  count of cycles with stall_if high, saturates at all-ones

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on rising clk.
- On reset:
  - EX, MEM and WB tag records become invalid.
  - stall_cycles = 0 and FSM = RUN.
  - All outputs read 0 in the cycle after reset asserts.
- ID decode (combinational, from id_instruction[6:0]):
  - rd = [11:7]; wen for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC.
  - rs1 = [19:15] used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 = [24:20] used by R, STORE, BRANCH.
  - is_load and is_mem (LOAD/STORE) flags.
  - Unknown opcode: no reads, no write.
  - Any tag equal to 0 never creates a hazard.
- Tag records: each holds {valid, rd, wen, is_load, is_mem, rs1, rs2}.
  - Each cycle with freeze=0: WB<=MEM, MEM<=EX, EX<=ID record.
  - The ID record enters EX as invalid when flush_ex=1 or id_valid=0.
- Forwarding (combinational on EX record):
  - fwd_a = 01 if MEM.valid & MEM.wen & MEM.rd==EX.rs1 != 0.
  - Otherwise 10 on the same condition against WB.
  - Otherwise 00.
  - MEM has priority over WB. fwd_b is identical on rs2.
  - Both are 00 when EX is invalid.
- Load-use hazard: EX.valid & EX.is_load & EX.rd!=0 & rd matches a used ID rs1/rs2.
  - Response: stall_if=stall_id=1, flush_ex=1, for exactly one cycle.
  - Next cycle the load is in MEM and fwd selects 01.
- FSM states RUN and MEM_WAIT.
  - RUN -> MEM_WAIT when MEM.valid & MEM.is_mem & !dmem_ready.
  - MEM_WAIT -> RUN on dmem_ready.
  - While the wait condition holds (combinational, also in the first cycle): freeze=stall_if=stall_id=1; flush_id=flush_ex=0; records hold.
- Priority: freeze > branch flush > load-use stall.
  - ex_branch_taken with freeze=0: flush_id=1, flush_ex=1, stall_if=stall_id=0 (PC takes the target). Any simultaneous load-use stall is suppressed.
  - ex_branch_taken while frozen is ignored. The EX stage re-presents it after the freeze.
- stall_cycles: +1 on each cycle with stall_if=1; saturates at 2^CNT_W-1 and holds there.
- Reset mid-freeze or mid-stall aborts immediately, with no residual stall.

Decomposition:
- Shared package (core_pkg): opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
- Also in core_pkg:
  - fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB)
  - stage_tag_t struct
  - hz_state_t enum
- One sub-module, reg_use_decode: instruction -> {rd, wen, rs1, rs1_used, rs2, rs2_used, is_load, is_mem}. It is reusable by the control decoder.

Test Plan:
- Load-use: lw x5,0(x6)=0x00032283 then add x7,x5,x1=0x001283B3 with dmem_ready=1.
  - Required: one cycle of stall_if=stall_id=flush_ex=1.
  - Next cycle add in EX: fwd_a=01, fwd_b=00. stall_cycles=1.
- EX/MEM forward: addi x5,x0,1=0x00100293 then add x7,x5,x1.
  - Required: no stall; fwd_a=01 when add in EX.
  - With one nop between: fwd_a=10.
- x0 immunity: addi x0,x0,1=0x00100013 then add x7,x0,x0=0x000003B3.
  - Required: fwd_a=fwd_b=00, no stall.
- Branch flush coincident with a load-use pattern in ID, ex_branch_taken=1.
  - Required: flush_id=flush_ex=1, stall_if=0, stall_cycles unchanged.
- Memory wait: lw in MEM with dmem_ready=0 for 3 cycles.
  - Required: freeze=stall_if=1 for 3 cycles, records unchanged.
  - Cycle after dmem_ready=1: freeze=0. stall_cycles +3.
- Reset: assert reset during MEM_WAIT.
  - Required: next cycle all outputs 0, stall_cycles=0.
  - With CNT_W=4 and 20 stall cycles: counter reads 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I pipeline definitions: opcodes, forwarding selects, stage tag record
// and hazard FSM states.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_t;

  // Unused source/destination fields are stored as x0 so they can never match.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             is_load;
    logic             is_mem;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } stage_tag_t;

endpackage

// File: rtl/reg_use_decode.sv
// Register-usage decode of an RV32I instruction: which architectural registers it
// reads and writes, and whether it touches data memory.
module reg_use_decode
  import core_pkg::*;
(
  input  logic [31:0]      instruction,
  output logic [REG_W-1:0] rd,
  output logic             wen,
  output logic [REG_W-1:0] rs1,
  output logic             rs1_used,
  output logic [REG_W-1:0] rs2,
  output logic             rs2_used,
  output logic             is_load,
  output logic             is_mem
);

  logic unused_bits;

  assign rd          = instruction[11:7];
  assign rs1         = instruction[19:15];
  assign rs2         = instruction[24:20];
  assign unused_bits = ^{instruction[31:25], instruction[14:12]};

  always_comb begin
    wen      = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    is_load  = 1'b0;
    is_mem   = 1'b0;
    case (instruction[6:0])
      OP_R:      begin wen = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_IMM:    begin wen = 1'b1; rs1_used = 1'b1; end
      OP_LOAD:   begin wen = 1'b1; rs1_used = 1'b1; is_load = 1'b1; is_mem = 1'b1; end
      OP_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; is_mem = 1'b1; end
      OP_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_JAL:    wen = 1'b1;
      OP_JALR:   begin wen = 1'b1; rs1_used = 1'b1; end
      OP_LUI:    wen = 1'b1;
      OP_AUIPC:  wen = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I core: tracks EX/MEM/WB destination tags
// and drives stall/flush/freeze enables, ALU forwarding selects and a stall counter.
module hazard_controller
  import core_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int XLEN_REGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instruction,
  input  logic             id_valid,
  input  logic             ex_branch_taken,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  function automatic logic tag_live(input logic [REG_W-1:0] t);
    return (t != '0) && (32'(t) < 32'(XLEN_REGS));
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic [REG_W-1:0] rs,
                                        input logic       ex_valid,
                                        input stage_tag_t mem_t,
                                        input stage_tag_t wb_t);
    if (!ex_valid || !tag_live(rs))                 return FWD_RF;
    if (mem_t.valid && mem_t.wen && mem_t.rd == rs) return FWD_MEM;
    if (wb_t.valid && wb_t.wen && wb_t.rd == rs)    return FWD_WB;
    return FWD_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [REG_W-1:0] id_rd, id_rs1, id_rs2;
  logic             id_wen, id_rs1_used, id_rs2_used, id_is_load, id_is_mem;
  stage_tag_t       id_tag;
  stage_tag_t       ex_tag_p0, mem_tag_p1, wb_tag_p2;
  hz_state_t        state, state_nxt;
  fwd_sel_t         fwd_a_sel, fwd_b_sel;
  logic             mem_wait_req, load_use, stall_c;
  logic             unused_tags;

  reg_use_decode u_decode (
    .instruction (id_instruction),
    .rd          (id_rd),
    .wen         (id_wen),
    .rs1         (id_rs1),
    .rs1_used    (id_rs1_used),
    .rs2         (id_rs2),
    .rs2_used    (id_rs2_used),
    .is_load     (id_is_load),
    .is_mem      (id_is_mem)
  );

  // ---- ID: build the record that would enter EX ----
  always_comb begin
    id_tag         = '0;
    id_tag.valid   = id_valid && !flush_ex;
    id_tag.rd      = id_wen ? id_rd : '0;
    id_tag.wen     = id_wen;
    id_tag.is_load = id_is_load;
    id_tag.is_mem  = id_is_mem;
    id_tag.rs1     = id_rs1_used ? id_rs1 : '0;
    id_tag.rs2     = id_rs2_used ? id_rs2 : '0;
  end

  assign load_use = id_valid && ex_tag_p0.valid && ex_tag_p0.is_load && tag_live(ex_tag_p0.rd)
                 && ((id_rs1_used && id_rs1 == ex_tag_p0.rd) ||
                     (id_rs2_used && id_rs2 == ex_tag_p0.rd));

  assign mem_wait_req = mem_tag_p1.valid && mem_tag_p1.is_mem && !dmem_ready;

  // ---- ID -> EX -> MEM -> WB: only the valid bits are reset ----
  always_ff @(posedge clk) begin
    if (!freeze) begin
      ex_tag_p0  <= id_tag;
      mem_tag_p1 <= ex_tag_p0;
      wb_tag_p2  <= mem_tag_p1;
    end
    if (reset) begin
      ex_tag_p0.valid  <= 1'b0;
      mem_tag_p1.valid <= 1'b0;
      wb_tag_p2.valid  <= 1'b0;
    end
  end

  assign unused_tags = ^{mem_tag_p1, wb_tag_p2};

  // ---- EX: forwarding selects ----
  always_comb begin
    fwd_a_sel = fwd_pick(ex_tag_p0.rs1, ex_tag_p0.valid, mem_tag_p1, wb_tag_p2);
    fwd_b_sel = fwd_pick(ex_tag_p0.rs2, ex_tag_p0.valid, mem_tag_p1, wb_tag_p2);
  end

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;

  always_ff @(posedge clk) begin
    if (reset) state <= HZ_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HZ_RUN:      if (mem_wait_req) state_nxt = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (dmem_ready)   state_nxt = HZ_RUN;
      default:     state_nxt = HZ_RUN;
    endcase
  end

  // Freeze acts in the same cycle the wait is first seen; priority is
  // freeze, then branch redirect, then load-use bubble.
  always_comb begin
    freeze   = (state == HZ_MEM_WAIT) ? !dmem_ready : mem_wait_req;
    stall_c  = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (freeze) begin
      stall_c = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      stall_c  = 1'b1;
      flush_ex = 1'b1;
    end
  end

  assign stall_if = stall_c;
  assign stall_id = stall_c;

  always_ff @(posedge clk) begin
    if (reset)         stall_cycles <= '0;
    else if (stall_if) stall_cycles <= sat_inc(stall_cycles);
  end

endmodule
